// File: rtl/mult32x32_ctrl.sv
// mult32x32_ctrl: sequencer for a 32x32 multiplier built from 8x16 partial products.
// Optional zero-skip of all-zero multiplicand bytes: define MULT32X32_ZERO_SKIP_EN.
`default_nettype none

module mult32x32_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    output logic        busy,
    output logic        done,
    output logic [1:0]  a_sel,
    output logic        b_sel,
    output logic [5:0]  shift_sel,
    output logic        upd_prod,
    output logic        clr_prod
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [3:0] w_start_mask;
    logic [3:0] w_step_mask;
    logic [3:0] w_next;

`ifdef MULT32X32_ZERO_SKIP_EN
    logic [3:0] mask_q, mask_d;

    assign w_start_mask = {|a[31:24], |a[23:16], |a[15:8], |a[7:0]};
    assign w_step_mask  = mask_q;

    always_comb begin
        mask_d = mask_q;
        if (state_q == S_IDLE && start && !reset)
            mask_d = w_start_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mask_q <= 4'd0;
        else
            mask_q <= mask_d;
    end
`else
    logic unused_a;

    assign w_start_mask = 4'hF;
    assign w_step_mask  = 4'hF;
    assign unused_a     = ^a;
`endif

    // Lowest step index >= from whose A-byte is enabled; 8 means no step left.
    function automatic logic [3:0] f_next(input logic [3:0] from, input logic [3:0] mask);
        logic [3:0] r;
        r = 4'd8;
        for (int j = 7; j >= 0; j--) begin
            if (4'(j) >= from && mask[j[1:0]])
                r = 4'(j);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        w_next    = 4'd0;
        busy      = 1'b0;
        done      = 1'b0;
        a_sel     = 2'd0;
        b_sel     = 1'b0;
        shift_sel = 6'd0;
        upd_prod  = 1'b0;
        clr_prod  = 1'b0;
        case (state_q)
            S_IDLE: begin
                k_d = 3'd0;
                // start is masked during reset so no output can rise while held
                if (start && !reset) begin
                    clr_prod = 1'b1;
                    w_next   = f_next(4'd0, w_start_mask);
                    if (w_next[3]) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STEP;
                        k_d     = w_next[2:0];
                    end
                end
            end
            S_STEP: begin
                a_sel     = k_q[1:0];
                b_sel     = k_q[2];
                shift_sel = {1'b0, k_q[1:0], 3'b000} + {1'b0, k_q[2], 4'b0000};
                upd_prod  = 1'b1;
                busy      = 1'b1;
                w_next    = f_next({1'b0, k_q} + 4'd1, w_step_mask);
                if (w_next[3]) begin
                    state_d = S_DONE;
                    k_d     = 3'd0;
                end else begin
                    k_d = w_next[2:0];
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
                k_d     = 3'd0;
            end
            default: begin
                state_d = S_IDLE;
                k_d     = 3'd0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mult32x32_ctrl.sv
// tb_mult32x32_ctrl: randomized check of the multiplier sequencer against a*b,
// using a behavioural 8x16 arithmetic unit driven by the controller outputs.
`default_nettype none

module tb_mult32x32_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy, done, b_sel, upd_prod, clr_prod;
    logic [1:0]  a_sel;
    logic [5:0]  shift_sel;

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] prod;

    mult32x32_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .busy      (busy),
        .done      (done),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .shift_sel (shift_sel),
        .upd_prod  (upd_prod),
        .clr_prod  (clr_prod)
    );

    always #5 clk = ~clk;

    // Arithmetic unit: product register accumulating shifted 8x16 partial products.
    always @(posedge clk) begin
        if (clr_prod)
            prod <= 64'd0;
        else if (upd_prod)
            prod <= prod + ((64'(a[8*a_sel +: 8]) * 64'(b[16*b_sel +: 16])) << shift_sel);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({busy, done, a_sel, b_sel, shift_sel, upd_prod, clr_prod});
    endfunction

    // Entered at posedge+1 of the start cycle; leaves at posedge+1 of the cycle after done.
    task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input bit hold);
        int         steps[$];
        logic [3:0] m;
`ifdef MULT32X32_ZERO_SKIP_EN
        for (int i = 0; i < 4; i++) m[i] = (ai[8*i +: 8] != 8'd0);
`else
        m = 4'hF;
`endif
        for (int k = 0; k < 8; k++)
            if (m[k % 4]) steps.push_back(k);
        a = ai; b = bi; start = 1'b1;
        #4;
        chk("start_clr", 64'(clr_prod), 64'd1);
        chk("start_busy_done_upd", 64'({busy, done, upd_prod}), 64'd0);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        foreach (steps[i]) begin
            #4;
            chk("step_asel", 64'(a_sel), 64'(steps[i] % 4));
            chk("step_bsel", 64'(b_sel), 64'(steps[i] / 4));
            chk("step_shift", 64'(shift_sel), 64'(8 * (steps[i] % 4) + 16 * (steps[i] / 4)));
            chk("step_flags", 64'({busy, upd_prod, done, clr_prod}), 64'b1100);
            @(posedge clk); #1;
        end
        #4;
        chk("done_flags", 64'({done, busy, upd_prod, clr_prod}), 64'b1000);
        chk("done_sels", 64'({a_sel, b_sel, shift_sel}), 64'd0);
        chk("product", prod, 64'(ai) * 64'(bi));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        #4;
        chk("reset_outs_start_hi", outs(), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        #4;
        chk("idle_outs", outs(), 64'd0);
        @(posedge clk); #1;

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0);
        run_op(32'h00FF0000, 32'h0000BEEF, 1'b0);
        run_op(32'h00000000, 32'h13579BDF, 1'b0);
        run_op(32'h80000001, 32'hFFFF0001, 1'b0);

        // start held through a whole op: the next op begins right after done
        run_op(32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
        run_op(32'h0000A500, 32'h00010001, 1'b0);
        #4;
        chk("idle_after_b2b", outs(), 64'd0);
        @(posedge clk); #1;

        // reset asserted mid-cycle at cycle 4 of an operation
        a = 32'hFFFFFFFF; b = 32'h12345678; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outs", outs(), 64'd0);
        #2;
        chk("reset_no_done", 64'(done), 64'd0);
        @(posedge clk); #1 start = 1'b1;
        #4;
        chk("reset_hold_outs", outs(), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        #4;
        chk("post_reset_idle", outs(), 64'd0);
        @(posedge clk); #1;
        run_op(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra = ra & {{8{i[3]}}, {8{i[2]}}, 8'h00, {8{i[4]}}};
            run_op(ra, rb, 1'(i % 3 == 0));
        end
        start = 1'b0;
        #4;
        chk("final_idle", outs(), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
